fpaddsub_align_stage: RTL and testbench
=======================================

FPADDSUB_ALIGN_STAGE -- requirements
Module: fpaddsub_align_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all ports are listed below.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream presents a prealigned operand set.
- in_ready  out  1  block accepts the set this cycle.
- A  in  31  operand A {exp[30:23], frac[22:0]}.
- B  in  31  operand B, same format.
- Sa  in  1  sign of A.
- Sb  in  1  sign of B.
- Op  in  1  0 = add, 1 = subtract.
- ShiftDet  in  10  {ExpB-ExpA [4:0], ExpA-ExpB [4:0]}.
- InputExc  in  5  exception vector {any, ANaN, BNaN, AInf, BInf}.
- out_valid  out  1  aligned result available.
- out_ready  in  1  downstream consumes the result this cycle.
- Emax  out  8  exponent field of the larger-magnitude operand.
- Mmax  out  24  {hidden, frac} of the larger operand.
- Mmin  out  27  {hidden, frac, G, R, S} of the smaller operand, right-shifted.
- Smax  out  1  effective sign of the larger operand.
- OpEff  out  1  1 = magnitudes subtract.
- ExcOut  out  5  InputExc delayed with its data.

Function
REQ-002 The block SHALL be a two-stage pipeline (S1: compare/swap, S2: shift/sticky), each stage holding its own valid bit.
REQ-003 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-004 Stage k SHALL load when it is empty or its contents transfer out in the same cycle; otherwise it SHALL hold all data bits unchanged.
REQ-005 in_ready SHALL be ~S1_valid | (S1 loads into S2 this cycle), computed combinationally.
REQ-006 Latency SHALL be 2 cycles from accepted input to out_valid with out_ready held high, and throughput SHALL be 1 set per cycle.
REQ-007 With out_ready low and both stages full, in_ready SHALL be 0 and no data SHALL be lost or duplicated.
REQ-008 Effective B sign SHALL be SbE = Sb ^ Op.
REQ-009 OpEff SHALL be Sa ^ SbE.
REQ-010 A SHALL be the larger operand when A[30:0] >= B[30:0] as unsigned, so a tie selects A.
REQ-011 Otherwise B SHALL be the larger operand.
REQ-012 Smax SHALL be Sa when A is larger, else SbE.
REQ-013 The hidden bit SHALL be OR of the operand's exponent field; denormals SHALL get hidden bit 0 and no exponent adjustment.
REQ-014 The shift amount SHALL be ShiftDet[4:0] when A is larger, else ShiftDet[9:5].
REQ-015 The unsigned exponent-field difference SHALL also be computed locally from A and B.
REQ-016 If the local difference is 27 or more, Mmin SHALL be 26'b0 followed by S = OR of the smaller operand's 24-bit mantissa.
REQ-017 For differences 0..26, Mmin SHALL be ({mant,3'b000} >> shift) with S ORed with all bits shifted out.
REQ-018 Difference 0 SHALL give Mmin = {mant,3'b000}.
REQ-019 InputExc SHALL pass through both stages unmodified alongside its data; NaN/Inf inputs SHALL still be aligned normally.

Reset
REQ-020 While rst is high, both stage valid bits SHALL be 0, so out_valid = 0 and in_ready = 1 after the reset edge.
REQ-021 While rst is high, all data outputs (Emax, Mmax, Mmin, Smax, OpEff, ExcOut) SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight sets.
REQ-023 After reset deasserts, the first out_valid SHALL come no earlier than 2 cycles after the first accepted input.

Verification
REQ-024 The bench SHALL cover: 1.0+1.0 (A=B=0x3F800000 low 31 bits, Op=0) -> Emax=0x7F, Mmax=0x800000, Mmin=0x4000000, OpEff=0, Smax=0, out_valid 2 cycles after accept.
REQ-025 The bench SHALL cover: 1.0 - 8.0 (A exp 0x7F, B exp 0x82, ShiftDet={5'd3,5'd29}) -> B larger, Emax=0x82, Mmin=0x0800000, Smax=1, OpEff=1.
REQ-026 The bench SHALL cover: exponent difference 40 with min frac nonzero -> Mmin=27'h0000001; with min operand zero -> Mmin=0.
REQ-027 The bench SHALL cover: shift 24 with min mantissa 0x800001 -> Mmin=27'h0000005 (G=1, R=0, S=1).
REQ-028 The bench SHALL cover: random stream with out_ready toggled pseudo-randomly -> output order and count equal input order and count, and in_ready=0 exactly when both stages are full and not draining.
REQ-029 The bench SHALL cover: rst pulsed with 2 sets in flight -> out_valid=0 the same cycle, in_ready=1, and no stale set emerges afterwards.

Source files
------------

// File: rtl/fpaddsub_align_stage.sv
// fpaddsub_align_stage
//   Alignment front end of a single-precision add/subtract unit. Two-stage
//   valid/ready pipeline:
//     S1 compare/swap : picks the larger-magnitude operand, resolves the
//                       effective signs/op, selects the shift amount.
//     S2 shift/sticky : right-shifts the smaller mantissa into a 27-bit
//                       {hidden, frac, G, R, S} field with sticky collection.
// Ports
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   upstream handshake for {A, B, Sa, Sb, Op, ShiftDet, InputExc}
//   A, B                {exp[30:23], frac[22:0]} operand magnitudes
//   Sa, Sb, Op          operand signs and op (0 add, 1 subtract)
//   ShiftDet            {ExpB-ExpA[4:0], ExpA-ExpB[4:0]} from the prealign logic
//   InputExc            exception flags, carried unmodified with the data
//   out_valid/out_ready downstream handshake
//   Emax, Mmax, Mmin    aligned larger exponent/mantissa and shifted smaller mantissa
//   Smax, OpEff, ExcOut result sign, effective subtract, delayed exceptions
module fpaddsub_align_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] A,
    input  logic [30:0] B,
    input  logic        Sa,
    input  logic        Sb,
    input  logic        Op,
    input  logic [9:0]  ShiftDet,
    input  logic [4:0]  InputExc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Emax,
    output logic [23:0] Mmax,
    output logic [26:0] Mmin,
    output logic        Smax,
    output logic        OpEff,
    output logic [4:0]  ExcOut
);

    typedef struct packed {
        logic [7:0]  emax;
        logic [23:0] mmax;
        logic [23:0] mmin;   // unshifted {hidden, frac} of the smaller operand
        logic [4:0]  shamt;
        logic        far;    // exponent gap >= 27: everything lands in sticky
        logic        smax;
        logic        opeff;
        logic [4:0]  exc;
    } s1_t;

    typedef struct packed {
        logic [7:0]  emax;
        logic [23:0] mmax;
        logic [26:0] mmin;
        logic        smax;
        logic        opeff;
        logic [4:0]  exc;
    } s2_t;

    // vld_pipe[1] = S1 full, vld_pipe[2] = S2 full
    logic [2:1] vld_pipe;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    logic       s1_load, s2_load;

    // A stage may load when empty or when its current set leaves this cycle.
    assign s2_load  = ~vld_pipe[2] | out_ready;
    assign s1_load  = ~vld_pipe[1] | s2_load;
    assign in_ready = s1_load;

    // ---------------- S1: compare / swap ----------------
    logic       sbe, a_big;
    logic [7:0] ea, eb, ediff;

    always_comb begin
        sbe   = Sb ^ Op;
        a_big = (A >= B);   // tie keeps A as the larger operand
        ea    = A[30:23];
        eb    = B[30:23];
        ediff = a_big ? (ea - eb) : (eb - ea);

        s1_d       = '0;
        s1_d.smax  = a_big ? Sa : sbe;
        s1_d.opeff = Sa ^ sbe;
        s1_d.exc   = InputExc;
        s1_d.far   = (ediff >= 8'd27);
        if (a_big) begin
            s1_d.emax  = ea;
            s1_d.mmax  = {|ea, A[22:0]};
            s1_d.mmin  = {|eb, B[22:0]};
            s1_d.shamt = ShiftDet[4:0];
        end else begin
            s1_d.emax  = eb;
            s1_d.mmax  = {|eb, B[22:0]};
            s1_d.mmin  = {|ea, A[22:0]};
            s1_d.shamt = ShiftDet[9:5];
        end
    end

    // ---------------- S2: shift / sticky ----------------
    logic [26:0] ext, shifted, lost_mask;
    logic        sticky;

    always_comb begin
        ext       = {s1_q.mmin, 3'b000};
        shifted   = ext >> s1_q.shamt;
        // Low shamt bits of ext are the ones that fall off the right end.
        lost_mask = (27'h1 << s1_q.shamt) - 27'h1;
        sticky    = |(ext & lost_mask);

        s2_d       = '0;
        s2_d.emax  = s1_q.emax;
        s2_d.mmax  = s1_q.mmax;
        s2_d.smax  = s1_q.smax;
        s2_d.opeff = s1_q.opeff;
        s2_d.exc   = s1_q.exc;
        if (s1_q.far)
            s2_d.mmin = {26'b0, |s1_q.mmin};
        else
            s2_d.mmin = {shifted[26:1], shifted[0] | sticky};
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_load) vld_pipe[1] <= in_valid;
            if (s2_load) vld_pipe[2] <= vld_pipe[1];
            if (s1_load && in_valid)    s1_q <= s1_d;
            if (s2_load && vld_pipe[1]) s2_q <= s2_d;
        end
    end

    assign out_valid = vld_pipe[2];
    assign Emax      = s2_q.emax;
    assign Mmax      = s2_q.mmax;
    assign Mmin      = s2_q.mmin;
    assign Smax      = s2_q.smax;
    assign OpEff     = s2_q.opeff;
    assign ExcOut    = s2_q.exc;

endmodule

// File: tb/tb_fpaddsub_align_stage.sv
module tb_fpaddsub_align_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [30:0] A, B;
    logic        Sa, Sb, Op;
    logic [9:0]  ShiftDet;
    logic [4:0]  InputExc;
    logic        out_valid, out_ready;
    logic [7:0]  Emax;
    logic [23:0] Mmax;
    logic [26:0] Mmin;
    logic        Smax, OpEff;
    logic [4:0]  ExcOut;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fpaddsub_align_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sa(Sa), .Sb(Sb), .Op(Op), .ShiftDet(ShiftDet),
        .InputExc(InputExc), .out_valid(out_valid), .out_ready(out_ready),
        .Emax(Emax), .Mmax(Mmax), .Mmin(Mmin), .Smax(Smax), .OpEff(OpEff),
        .ExcOut(ExcOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one set with out_ready high, check 2-cycle latency and all fields.
    task automatic vec(input string tag, input logic [30:0] a, input logic [30:0] b,
                       input logic sa, input logic sb, input logic op,
                       input logic [9:0] sd, input logic [4:0] exc,
                       input logic [7:0] e_emax, input logic [23:0] e_mmax,
                       input logic [26:0] e_mmin, input logic e_smax, input logic e_opeff);
        A = a; B = b; Sa = sa; Sb = sb; Op = op; ShiftDet = sd; InputExc = exc;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, ".lat2"}, out_valid, 1);
        chk({tag, ".Emax"}, Emax, e_emax);
        chk({tag, ".Mmax"}, Mmax, e_mmax);
        chk({tag, ".Mmin"}, Mmin, e_mmin);
        chk({tag, ".Smax"}, Smax, e_smax);
        chk({tag, ".OpEff"}, OpEff, e_opeff);
        chk({tag, ".ExcOut"}, ExcOut, exc);
        @(posedge clk); #1;
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    logic [30:0] q[$];
    logic [30:0] e;
    int          occ, nacc, ndel, stale;
    logic [7:0]  tag;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Sa = 0; Sb = 0; Op = 0; ShiftDet = '0; InputExc = '0;
        @(posedge clk); #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.Emax", Emax, 0);
        chk("rst.Mmin", Mmin, 0);
        chk("rst.ExcOut", ExcOut, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 + 1.0
        vec("one_plus_one", 31'h3F800000, 31'h3F800000, 0, 0, 0, 10'd0, 5'd0,
            8'h7F, 24'h800000, 27'h4000000, 0, 0);
        // 1.0 - 8.0 : B larger, shift 3
        vec("one_minus_eight", 31'h3F800000, 31'h41000000, 0, 0, 1, {5'd3, 5'd29}, 5'd0,
            8'h82, 24'h800000, 27'h0800000, 1, 1);
        // gap 40, min frac nonzero -> only sticky; exceptions ride along
        vec("gap40_sticky", {8'hA7, 23'h0}, {8'h7F, 23'h1}, 0, 0, 0, {5'd24, 5'd8}, 5'b10100,
            8'hA7, 24'h800000, 27'h0000001, 0, 0);
        // gap 40, min operand zero
        vec("gap40_zero", {8'h28, 23'h123456}, 31'h0, 0, 0, 0, {5'd24, 5'd8}, 5'b11000,
            8'h28, 24'h923456, 27'h0, 0, 0);
        // shift 24 on 0x800001 -> G=1 R=0 S=1
        vec("shift24", {8'h28, 23'h0}, {8'h10, 23'h1}, 1, 0, 0, {5'd8, 5'd24}, 5'd0,
            8'h28, 24'h800000, 27'h0000005, 1, 1);
        // tie selects A, opposite signs
        vec("tie", 31'h40400000, 31'h40400000, 0, 1, 0, 10'd0, 5'd0,
            8'h80, 24'hC00000, 27'h6000000, 0, 1);
        // denormal smaller operand: hidden 0, no exponent fixup
        vec("denorm", {8'h01, 23'h0}, {8'h00, 23'h400000}, 0, 0, 0, {5'd31, 5'd1}, 5'd0,
            8'h01, 24'h800000, 27'h1000000, 0, 0);

        // Random stream with backpressure; A's exponent is a sequence tag.
        occ = 0; nacc = 0; ndel = 0; tag = 8'd1;
        B = '0; Sa = 0; Sb = 0; Op = 0; ShiftDet = '0; InputExc = '0;
        for (int n = 0; n < 300; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 2) != 0;
            A = {tag, 23'($urandom)};
            @(negedge clk);
            chk("rnd.in_ready", in_ready, (occ == 2 && !out_ready) ? 0 : 1);
            if (occ == 0) chk("rnd.idle", out_valid, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rnd.spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rnd.Emax", Emax, e[30:23]);
                    chk("rnd.Mmax", Mmax, {1'b1, e[22:0]});
                end
                occ--; ndel++;
            end
            if (in_valid && in_ready) begin
                q.push_back(A);
                occ++; nacc++;
                tag = (tag == 8'd254) ? 8'd1 : tag + 8'd1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 10 && occ > 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) chk("drain.spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("drain.Emax", Emax, e[30:23]);
                end
                occ--; ndel++;
            end
            @(posedge clk); #1;
        end
        chk("rnd.count", ndel, nacc);
        chk("rnd.left", q.size(), 0);

        // Reset with two sets in flight
        out_ready = 1'b0; in_valid = 1'b1; InputExc = 5'b10001;
        A = {8'h50, 23'h0}; B = '0;
        @(posedge clk); #1;
        A = {8'h51, 23'h0};
        @(posedge clk); #1;
        A = {8'h52, 23'h0};
        chk("full.in_ready", in_ready, 0);
        chk("full.out_valid", out_valid, 1);
        rst = 1'b1; #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.Emax", Emax, 0);
        chk("midrst.ExcOut", ExcOut, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst = 1'b0;
        stale = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("midrst.stale", stale, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
